// File: rtl/cmd_parser_p.sv
// rtl/cmd_parser_p.sv - ASCII arithmetic command frame parser
//
// Parses frames of the form "I <U|S> <num1> <op> <num2> =" arriving one byte
// per data_valid beat and presents the decoded command until out_ready.
//
// Optional feature macro: CMD_PARSER_ERR_EN
//   defined   -> err/err_code report protocol(1), digit-count(2), range(3)
//                and overrun(4) errors as one-cycle pulses.
//   undefined -> err/err_code are held at 0; recovery behaviour is identical.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data[7:0]       received ASCII byte, sampled when data_valid=1
//   out_ready       consumer accepts the held command
//   out_valid       parsed command available (held until out_ready)
//   dtype           0 unsigned, 1 signed
//   op[1:0]         00 '+', 01 '-', 10 '*', 11 '/'
//   src1, src2      operands (two's complement when dtype=1)
//   err, err_code   one-cycle error pulse and its cause
module cmd_parser_p #(
  parameter int OPW    = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     data,
  input  logic           data_valid,
  input  logic           out_ready,
  output logic           out_valid,
  output logic           dtype,
  output logic [1:0]     op,
  output logic [OPW-1:0] src1,
  output logic [OPW-1:0] src2,
  output logic           err,
  output logic [2:0]     err_code
);

`ifdef CMD_PARSER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [OPW+3:0] TEN    = (OPW+4)'(10);
  localparam logic [OPW+3:0] LIM_U  = {4'b0, {OPW{1'b1}}};
  localparam logic [OPW+3:0] LIM_SP = {5'b0, {(OPW-1){1'b1}}};
  localparam logic [OPW+3:0] LIM_SN = LIM_SP + (OPW+4)'(1);
  localparam logic [3:0]     CNT_MAX = 4'(DIGITS);

  // The space that ends num2 is consumed inside NUM2, so EQ waits for '='.
  typedef enum logic [3:0] {
    S_IDLE, S_SP0, S_TYPE, S_SP1, S_NUM1, S_OP, S_SP2, S_NUM2, S_EQ, S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic            w_dtype_q, w_dtype_d;
  logic [1:0]      w_op_q, w_op_d;
  logic [OPW-1:0]  w_src1_q, w_src1_d, w_src2_q, w_src2_d;
  logic            neg_q, neg_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [OPW+3:0]  mag_q, mag_d;
  logic            out_valid_q, out_valid_d, dtype_q, dtype_d;
  logic [1:0]      op_q, op_d;
  logic [OPW-1:0]  src1_q, src1_d, src2_q, src2_d;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d;

  logic [OPW+3:0]  mag_next, lim;
  logic [OPW-1:0]  opnd;
  logic            is_digit, proto_err, clr_num;

  always_comb begin
    state_d     = state_q;
    w_dtype_d   = w_dtype_q;
    w_op_d      = w_op_q;
    w_src1_d    = w_src1_q;
    w_src2_d    = w_src2_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    out_valid_d = out_valid_q;
    dtype_d     = dtype_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    err_d       = 1'b0;
    err_code_d  = 3'd0;
    proto_err   = 1'b0;
    clr_num     = 1'b0;
    is_digit    = (data >= 8'h30) && (data <= 8'h39);
    mag_next    = mag_q * TEN + {{OPW{1'b0}}, data[3:0]};
    lim         = !w_dtype_q ? LIM_U : (neg_q ? LIM_SN : LIM_SP);
    opnd        = neg_q ? ({OPW{1'b0}} - mag_q[OPW-1:0]) : mag_q[OPW-1:0];

    // Release happens regardless of data; a byte in the same cycle is still
    // treated as overrun below.
    if (state_q == S_HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end

    if (data_valid) begin
      case (state_q)
        S_IDLE: if (data == 8'h49) begin
          state_d = S_SP0;
          clr_num = 1'b1;
        end
        S_SP0:  if (data == 8'h20) state_d = S_TYPE; else proto_err = 1'b1;
        S_TYPE: begin
          if (data == 8'h55 || data == 8'h53) begin
            w_dtype_d = (data == 8'h53);
            state_d   = S_SP1;
          end else proto_err = 1'b1;
        end
        S_SP1:  if (data == 8'h20) state_d = S_NUM1; else proto_err = 1'b1;
        S_NUM1, S_NUM2: begin
          if (data == 8'h2D && w_dtype_q && cnt_q == 4'd0 && !neg_q) begin
            neg_d = 1'b1;
          end else if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              err_d = 1'b1; err_code_d = 3'd2; state_d = S_IDLE; clr_num = 1'b1;
            end else if (mag_next > lim) begin
              err_d = 1'b1; err_code_d = 3'd3; state_d = S_IDLE; clr_num = 1'b1;
            end else begin
              mag_d = mag_next;
              cnt_d = cnt_q + 4'd1;
            end
          end else if (data == 8'h20 && cnt_q != 4'd0) begin
            if (state_q == S_NUM1) begin
              w_src1_d = opnd;
              state_d  = S_OP;
            end else begin
              w_src2_d = opnd;
              state_d  = S_EQ;
            end
            clr_num = 1'b1;
          end else proto_err = 1'b1;
        end
        S_OP: begin
          case (data)
            8'h2B:   begin w_op_d = 2'b00; state_d = S_SP2; end
            8'h2D:   begin w_op_d = 2'b01; state_d = S_SP2; end
            8'h2A:   begin w_op_d = 2'b10; state_d = S_SP2; end
            8'h2F:   begin w_op_d = 2'b11; state_d = S_SP2; end
            default: proto_err = 1'b1;
          endcase
        end
        S_SP2:  if (data == 8'h20) state_d = S_NUM2; else proto_err = 1'b1;
        S_EQ: begin
          if (data == 8'h3D) begin
            out_valid_d = 1'b1;
            dtype_d     = w_dtype_q;
            op_d        = w_op_q;
            src1_d      = w_src1_q;
            src2_d      = w_src2_q;
            state_d     = S_HOLD;
          end else proto_err = 1'b1;
        end
        S_HOLD: begin
          err_d      = 1'b1;
          err_code_d = 3'd4;
        end
        default: state_d = S_IDLE;
      endcase

      if (proto_err) begin
        err_d      = 1'b1;
        err_code_d = 3'd1;
        clr_num    = 1'b1;
        state_d    = (data == 8'h49) ? S_SP0 : S_IDLE;
      end
    end

    if (clr_num) begin
      neg_d = 1'b0;
      cnt_d = 4'd0;
      mag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      w_dtype_q   <= 1'b0;
      w_op_q      <= 2'b00;
      w_src1_q    <= '0;
      w_src2_q    <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= 4'd0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
      dtype_q     <= 1'b0;
      op_q        <= 2'b00;
      src1_q      <= '0;
      src2_q      <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      w_dtype_q   <= w_dtype_d;
      w_op_q      <= w_op_d;
      w_src1_q    <= w_src1_d;
      w_src2_q    <= w_src2_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
      dtype_q     <= dtype_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dtype     = dtype_q;
  assign op        = op_q;
  assign src1      = src1_q;
  assign src2      = src2_q;
  assign err       = ERR_EN & err_q;
  assign err_code  = ERR_EN ? err_code_q : 3'd0;

endmodule

// File: tb/tb_cmd_parser_p.sv
// tb/tb_cmd_parser_p.sv - directed self-checking bench for cmd_parser_p
module tb_cmd_parser_p;

`ifdef CMD_PARSER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        data_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, dtype, err;
  logic [1:0]  op;
  logic [15:0] src1, src2;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  logic       err_any;
  logic [2:0] last_code;

  cmd_parser_p #(.OPW(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .out_ready(out_ready), .out_valid(out_valid), .dtype(dtype), .op(op),
    .src1(src1), .src2(src2), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ec(input logic [2:0] c);
    return ERR_EN ? c : 3'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data       = b;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    if (err) begin
      err_any   = 1'b1;
      last_code = err_code;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic release_hold(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(tag, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    err_any = 1'b0; last_code = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ov", {31'd0, out_valid}, 0);
    check("rst_dtype", {31'd0, dtype}, 0);
    check("rst_op", {30'd0, op}, 0);
    check("rst_src1", {16'd0, src1}, 0);
    check("rst_src2", {16'd0, src2}, 0);
    check("rst_err", {29'd0, err_code}, 0);

    err_any = 1'b0;
    send_str("I U 123 + 45 =");
    check("u_ov", {31'd0, out_valid}, 1);
    check("u_dtype", {31'd0, dtype}, 0);
    check("u_op", {30'd0, op}, 0);
    check("u_src1", {16'd0, src1}, 32'h007B);
    check("u_src2", {16'd0, src2}, 32'h002D);
    check("u_noerr", {31'd0, err_any}, 0);
    release_hold("u_rel");

    send_str("I S -300 * 7 =");
    check("s_ov", {31'd0, out_valid}, 1);
    check("s_dtype", {31'd0, dtype}, 1);
    check("s_op", {30'd0, op}, 2);
    check("s_src1", {16'd0, src1}, 32'hFED4);
    check("s_src2", {16'd0, src2}, 32'h0007);
    release_hold("s_rel");

    send_str("I S -32768 / 1 =");
    check("smin_op", {30'd0, op}, 3);
    check("smin_src1", {16'd0, src1}, 32'h8000);
    release_hold("smin_rel");

    send_str("I U 6553");
    send_byte("6");
    check("rng_err", {31'd0, err}, {31'd0, ERR_EN});
    check("rng_code", {29'd0, err_code}, {29'd0, ec(3'd3)});
    @(posedge clk); #1;
    check("rng_pulse", {31'd0, err}, 0);
    err_any = 1'b0;
    send_str("I U 7 + 8 =");
    check("rng_after_src1", {16'd0, src1}, 7);
    check("rng_after_src2", {16'd0, src2}, 8);
    check("rng_after_noerr", {31'd0, err_any}, 0);
    release_hold("rng_rel");

    send_str("I U 12345");
    send_byte("6");
    check("dig_code", {29'd0, err_code}, {29'd0, ec(3'd2)});
    send_str("I");
    send_byte("X");
    check("proto_code", {29'd0, err_code}, {29'd0, ec(3'd1)});

    err_any = 1'b0; last_code = 3'd0;
    send_str("I U 1 I U 2 + 3 =");
    check("resync_code", {29'd0, last_code}, {29'd0, ec(3'd1)});
    check("resync_ov", {31'd0, out_valid}, 1);
    check("resync_src1", {16'd0, src1}, 2);
    check("resync_src2", {16'd0, src2}, 3);
    release_hold("resync_rel");

    send_str("I U 5 + 6 =");
    check("hold_ov", {31'd0, out_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      send_byte("I");
      check("hold_code", {29'd0, err_code}, {29'd0, ec(3'd4)});
      check("hold_src1", {16'd0, src1}, 5);
    end
    check("hold_ov_kept", {31'd0, out_valid}, 1);
    out_ready = 1'b1;
    send_byte("I");
    out_ready = 1'b0;
    check("hold_rel_ov", {31'd0, out_valid}, 0);
    check("hold_rel_code", {29'd0, err_code}, {29'd0, ec(3'd4)});
    err_any = 1'b0;
    send_str(" U 3 + 4 =");
    check("hold_drop_ov", {31'd0, out_valid}, 0);
    check("hold_drop_noerr", {31'd0, err_any}, 0);

    send_str("I U 12");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ov", {31'd0, out_valid}, 0);
    check("mrst_src1", {16'd0, src1}, 0);
    check("mrst_src2", {16'd0, src2}, 0);
    check("mrst_err", {31'd0, err}, 0);
    err_any = 1'b0;
    send_str("I U 9 - 8 =");
    check("mrst_op", {30'd0, op}, 1);
    check("mrst_src1b", {16'd0, src1}, 9);
    check("mrst_src2b", {16'd0, src2}, 8);
    check("mrst_noerr", {31'd0, err_any}, 0);
    release_hold("mrst_rel");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
